usp_auth_arbiter: RTL

Round-robin arbiter and sequencer that shares a single USP authentication datapath between `NUM_EV` electric-vehicle requesters. It sits between the EV front-ends and the USP verify path. It latches the winning requester's ID, encrypted message and PUF response, then issues a one-cycle `send_req` to the USP. It waits for the USP verdict and returns a per-requester ack/pass pulse, with an optional watchdog on the USP response.

---
 rtl/usp_auth_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/usp_auth_arbiter.sv
// usp_auth_arbiter: round-robin arbiter sharing one USP authentication
// datapath between NUM_EV requesters. Latches the winner's ID, message and
// PUF bit, pulses usp_send_req, waits for usp_done and returns an ack/pass
// pulse to the granted requester.
// Build option: define ARB_TIMEOUT_EN to add a TIMEOUT-cycle watchdog on the
// USP response; when undefined the WAIT state holds until usp_done and
// timeout_err is tied low.
module usp_auth_arbiter #(
   parameter  int unsigned NUM_EV  = 4,
   parameter  int unsigned TIMEOUT = 16,
   localparam int unsigned IW      = $clog2(NUM_EV)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_EV-1:0]    ev_req,
   input  logic [16*NUM_EV-1:0] ev_id_in,
   input  logic [64*NUM_EV-1:0] ev_msg_in,
   input  logic [NUM_EV-1:0]    ev_puf_in,
   output logic [NUM_EV-1:0]    ev_ack,
   output logic [NUM_EV-1:0]    ev_pass,
   output logic [15:0]          usp_ev_id,
   output logic [63:0]          usp_msg,
   output logic                 usp_puf,
   output logic                 usp_send_req,
   input  logic                 usp_done,
   input  logic                 usp_auth_pass,
   output logic                 busy,
   output logic [IW-1:0]        grant_idx,
   output logic [7:0]           fail_cnt,
   output logic                 timeout_err
);

   localparam int unsigned ID_W  = 16;
   localparam int unsigned MSG_W = 64;
   localparam int unsigned CNT_W = 8;

   // Parameter range guards
   if (NUM_EV < 2 || NUM_EV > 8) begin : g_bad_num_ev
      $error("usp_auth_arbiter: NUM_EV must be 2..8");
   end
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("usp_auth_arbiter: TIMEOUT must be 2..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       last_q, last_d;
   logic [IW-1:0]       grant_d;
   logic [ID_W-1:0]     id_d;
   logic [MSG_W-1:0]    msg_d;
   logic                puf_d;
   logic                send_d;
   logic [NUM_EV-1:0]   ack_d, pass_d;
   logic [CNT_W-1:0]    fail_d;
   logic                busy_d;
   logic                resolve, verdict;

   logic [IW-1:0]       cand;
   logic [IW-1:0]       win_idx;
   logic                win_vld;
   logic [NUM_EV-1:0]   grant_oh;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0]    wd_q, wd_d;
   logic                tmo_d;
`endif

   assign grant_oh = NUM_EV'(1) << grant_idx;

   // Round-robin search: scan downward so the slot right after last wins
   always_comb begin
      cand    = '0;
      win_idx = '0;
      win_vld = 1'b0;
      for (int k = NUM_EV; k >= 1; k--) begin
         cand = IW'((int'(last_q) + k) % NUM_EV);
         if (ev_req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_idx;
      id_d    = usp_ev_id;
      msg_d   = usp_msg;
      puf_d   = usp_puf;
      send_d  = 1'b0;
      ack_d   = '0;
      pass_d  = '0;
      fail_d  = fail_cnt;
      resolve = 1'b0;
      verdict = 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_d    = wd_q;
      tmo_d   = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               state_d = ST_WAIT;
               last_d  = win_idx;
               grant_d = win_idx;
               id_d    = ev_id_in[ID_W*int'(win_idx) +: ID_W];
               msg_d   = ev_msg_in[MSG_W*int'(win_idx) +: MSG_W];
               puf_d   = ev_puf_in[win_idx];
               send_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
               wd_d    = '0;
`endif
            end
         end

         ST_WAIT: begin
`ifdef ARB_TIMEOUT_EN
            wd_d = wd_q + CNT_W'(1);
`endif
            // A real verdict beats a watchdog expiry on the same cycle
            if (usp_done) begin
               resolve = 1'b1;
               verdict = usp_auth_pass;
            end
`ifdef ARB_TIMEOUT_EN
            else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
               resolve = 1'b1;
               verdict = 1'b0;
               tmo_d   = 1'b1;
            end
`endif
            if (resolve) begin
               state_d = ST_RESP;
               ack_d   = grant_oh;
               pass_d  = verdict ? grant_oh : '0;
               if (!verdict && fail_cnt != {CNT_W{1'b1}}) begin
                  fail_d = fail_cnt + CNT_W'(1);
               end
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_q       <= IW'(NUM_EV - 1);
         grant_idx    <= '0;
         usp_ev_id    <= '0;
         usp_msg      <= '0;
         usp_puf      <= 1'b0;
         usp_send_req <= 1'b0;
         ev_ack       <= '0;
         ev_pass      <= '0;
         fail_cnt     <= '0;
         busy         <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         wd_q         <= '0;
         timeout_err  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         grant_idx    <= grant_d;
         usp_ev_id    <= id_d;
         usp_msg      <= msg_d;
         usp_puf      <= puf_d;
         usp_send_req <= send_d;
         ev_ack       <= ack_d;
         ev_pass      <= pass_d;
         fail_cnt     <= fail_d;
         busy         <= busy_d;
`ifdef ARB_TIMEOUT_EN
         wd_q         <= wd_d;
         timeout_err  <= tmo_d;
`endif
      end
   end

`ifndef ARB_TIMEOUT_EN
   assign timeout_err = 1'b0;
`endif

endmodule
